// File: rtl/benes_pkg.sv
// Shared constants and types for the benes_8 routing controller: choice width,
// pipe latency, per-stage choice masks and the admission FSM states.
package benes_pkg;

  localparam int CHOICE_W  = 40;
  localparam int BENES_LAT = 5;

  typedef logic [CHOICE_W-1:0] choice_t;

  // Entry k selects the choice bits consumed by benes register stage k+1.
  localparam choice_t STAGE_MASK [BENES_LAT] = '{
    40'h00_0000_00FF,
    40'h00_00F0_0F00,
    40'h00_0F00_F000,
    40'h00_F00F_0000,
    40'hFF_0000_0000
  };

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/benes_choice_skew.sv
// Carries each admitted wavefront's config down the 5-stage pipe so every benes
// stage sees the choice bits of the wavefront it currently holds.
module benes_choice_skew
  import benes_pkg::*;
#(
  parameter int IDX_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fire,
  input  choice_t              fire_cfg,
  input  logic [IDX_W-1:0]     fire_idx,
  output choice_t              skew_choice,
  output logic [BENES_LAT-1:0] valid_pipe,
  output logic [IDX_W-1:0]     out_idx
);

  // cfg_q[k] feeds benes stage k+1; it follows the wavefront one stage per edge.
  choice_t          cfg_q [1:BENES_LAT-1];
  logic [IDX_W-1:0] idx_q [BENES_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_pipe <= '0;
      for (int k = 1; k < BENES_LAT; k++) cfg_q[k] <= '0;
      for (int k = 0; k < BENES_LAT; k++) idx_q[k] <= '0;
    end else begin
      // NOTE: nonblocking assignments, so each stage samples its neighbour's pre-edge value.
      valid_pipe <= {valid_pipe[BENES_LAT-2:0], fire};
      idx_q[0]   <= fire ? fire_idx : '0;
      for (int k = 1; k < BENES_LAT; k++) idx_q[k] <= idx_q[k-1];
      if (fire) cfg_q[1] <= fire_cfg;
      // A stage only advances when a wavefront moves into it; otherwise it holds.
      for (int k = 2; k < BENES_LAT; k++) begin
        if (valid_pipe[k-2]) cfg_q[k] <= cfg_q[k-1];
      end
    end
  end

  always_comb begin
    // NOTE: default assigned first, so no path leaves skew_choice unassigned (no latch).
    skew_choice = '0;
    for (int k = 1; k < BENES_LAT; k++) begin
      skew_choice = skew_choice | (cfg_q[k] & STAGE_MASK[k]);
    end
  end

  assign out_idx = idx_q[BENES_LAT-1];

endmodule

// File: rtl/benes_8_route_ctrl.sv
// Admission sequencer for the registered 8-port Benes network: config table,
// downstream credit gating, drain FSM and the stage-skewed choice bus.
module benes_8_route_ctrl
  import benes_pkg::*;
#(
  parameter int NUM_CFG = 4,
  parameter int CREDITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_wr_en,
  input  logic [$clog2(NUM_CFG)-1:0] cfg_wr_idx,
  input  logic [CHOICE_W-1:0]        cfg_wr_data,
  input  logic                       in_valid,
  input  logic [$clog2(NUM_CFG)-1:0] in_cfg_idx,
  output logic                       in_ready,
  output logic [CHOICE_W-1:0]        choice,
  output logic                       dp_hold,
  output logic                       out_valid,
  output logic [$clog2(NUM_CFG)-1:0] out_cfg_idx,
  input  logic                       credit_ret,
  input  logic                       drain_req,
  output logic                       drain_done,
  output logic                       busy,
  output logic                       err_credit
);

  localparam int IDX_W = $clog2(NUM_CFG);
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

  choice_t              cfg_table [NUM_CFG];
  choice_t              fire_cfg;
  choice_t              skew_choice;
  logic [BENES_LAT-1:0] valid_pipe;
  logic [CNT_W-1:0]     credit_cnt;
  state_e               state;
  state_e               state_next;
  logic                 fire;

  assign in_ready  = (state == RUN) && !dp_hold && (credit_cnt != '0);
  assign fire      = in_valid && in_ready;
  // Stage 1 samples its bits on the fire edge, so they come straight from the table.
  assign fire_cfg  = cfg_table[in_cfg_idx];
  assign choice    = (fire_cfg & STAGE_MASK[0]) | skew_choice;
  assign busy      = |valid_pipe;
  assign out_valid = valid_pipe[BENES_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dp_hold <= 1'b1;
    else      dp_hold <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the table is tiny and must read as zero after reset, so it is reset like plain flops.
      for (int i = 0; i < NUM_CFG; i++) cfg_table[i] <= '0;
    end else if (cfg_wr_en) begin
      cfg_table[cfg_wr_idx] <= cfg_wr_data;
    end
  end

  // A return in the same cycle as a fire is legitimate even at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt <= CREDIT_MAX;
      err_credit <= 1'b0;
    end else begin
      case ({fire, credit_ret})
        2'b10: credit_cnt <= credit_cnt - CNT_W'(1);
        2'b01: begin
          if (credit_cnt == CREDIT_MAX) err_credit <= 1'b1;
          else                          credit_cnt <= credit_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      drain_done <= 1'b0;
    end else begin
      state      <= state_next;
      drain_done <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (drain_req)          state_next = DRAIN;
      DRAIN:   if (valid_pipe == '0)   state_next = DONE;
      DONE:    if (!drain_req)         state_next = RUN;
      default:                         state_next = RUN;
    endcase
  end

  benes_choice_skew #(
    .IDX_W (IDX_W)
  ) u_skew (
    .clk         (clk),
    .rst         (rst),
    .fire        (fire),
    .fire_cfg    (fire_cfg),
    .fire_idx    (in_cfg_idx),
    .skew_choice (skew_choice),
    .valid_pipe  (valid_pipe),
    .out_idx     (out_cfg_idx)
  );

endmodule

// File: tb/tb_benes_8_route_ctrl.sv
// Directed bench for benes_8_route_ctrl: a per-stage config tracker checks the
// skewed choice bits and output valid; credits and drain are checked by hand.
module tb_benes_8_route_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr_en;
  logic [1:0]  cfg_wr_idx;
  logic [39:0] cfg_wr_data;
  logic        in_valid;
  logic [1:0]  in_cfg_idx;
  logic        in_ready;
  logic [39:0] choice;
  logic        dp_hold;
  logic        out_valid;
  logic [1:0]  out_cfg_idx;
  logic        credit_ret;
  logic        drain_req;
  logic        drain_done;
  logic        busy;
  logic        err_credit;

  always #5 clk = ~clk;

  benes_8_route_ctrl #(
    .NUM_CFG (4),
    .CREDITS (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_idx  (cfg_wr_idx),
    .cfg_wr_data (cfg_wr_data),
    .in_valid    (in_valid),
    .in_cfg_idx  (in_cfg_idx),
    .in_ready    (in_ready),
    .choice      (choice),
    .dp_hold     (dp_hold),
    .out_valid   (out_valid),
    .out_cfg_idx (out_cfg_idx),
    .credit_ret  (credit_ret),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .busy        (busy),
    .err_credit  (err_credit)
  );

  localparam logic [39:0] CFG_ID  = 40'hAA_AAAA_AAAA;
  localparam logic [39:0] CFG_SW  = 40'h55_5555_5555;
  localparam logic [39:0] CFG_X   = 40'hC3_5A96_0FF0;
  localparam logic [39:0] CFG_Y   = 40'h0F_F0A5_3CC3;
  localparam logic [39:0] CFG_NEW = 40'h3C_3C3C_3C3C;

  int total = 0;
  int bad   = 0;

  // Expected table contents and the wavefront tracker: m_v[k] = fired k edges ago.
  logic [39:0] m_tab [4];
  logic        m_v   [1:5];
  logic [39:0] m_cfg [1:5];
  logic [1:0]  m_idx [1:5];
  logic        exp_rdy;

  function automatic logic [39:0] stage_mask(input int k);
    case (k)
      1:       return 40'h00_0000_00FF;
      2:       return 40'h00_00F0_0F00;
      3:       return 40'h00_0F00_F000;
      4:       return 40'h00_F00F_0000;
      default: return 40'hFF_0000_0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 1; k <= 5; k++) begin
      m_v[k]   = 1'b0;
      m_cfg[k] = '0;
      m_idx[k] = '0;
    end
    for (int i = 0; i < 4; i++) m_tab[i] = '0;
  endtask

  // Called just after an edge with inputs driven; returns just after the next edge.
  task automatic step();
    logic        f;
    logic [39:0] c;
    logic [1:0]  ix;
    logic        any;
    #1;
    check("in_ready", in_ready, exp_rdy);
    if (in_valid) check("s1_bits", choice & stage_mask(1), m_tab[in_cfg_idx] & stage_mask(1));
    f  = in_valid & exp_rdy;
    c  = m_tab[in_cfg_idx];
    ix = in_cfg_idx;
    @(posedge clk);
    if (cfg_wr_en) m_tab[cfg_wr_idx] = cfg_wr_data;
    for (int k = 5; k >= 2; k--) begin
      m_v[k]   = m_v[k-1];
      m_cfg[k] = m_cfg[k-1];
      m_idx[k] = m_idx[k-1];
    end
    m_v[1]   = f;
    m_cfg[1] = c;
    m_idx[1] = ix;
    #1;
    any = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      if (m_v[k-1]) check($sformatf("s%0d_bits", k), choice & stage_mask(k), m_cfg[k-1] & stage_mask(k));
    end
    for (int k = 1; k <= 5; k++) any = any | m_v[k];
    check("out_valid", out_valid, m_v[5]);
    if (m_v[5]) check("out_cfg_idx", out_cfg_idx, m_idx[5]);
    check("busy", busy, any);
  endtask

  initial begin
    rst = 1'b0; cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_data = '0;
    in_valid = 1'b0; in_cfg_idx = '0; credit_ret = 1'b0; drain_req = 1'b0;
    exp_rdy = 1'b0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_dp_hold", dp_hold, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_choice", choice, 40'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_drain_done", drain_done, 1'b0);
    check("rst_err_credit", err_credit, 1'b0);

    // Release: datapath still held until the first edge, then ready
    rst = 1'b1;
    #1;
    check("rel_dp_hold", dp_hold, 1'b1);
    cfg_wr_en = 1'b1; cfg_wr_idx = 2'd0; cfg_wr_data = CFG_ID;
    step();
    check("rel_dp_hold_low", dp_hold, 1'b0);
    exp_rdy = 1'b1;
    cfg_wr_idx = 2'd1; cfg_wr_data = CFG_SW; step();
    cfg_wr_idx = 2'd2; cfg_wr_data = CFG_X;  step();
    cfg_wr_idx = 2'd3; cfg_wr_data = CFG_Y;  step();
    cfg_wr_en = 1'b0;

    // Identity, then all-swap, single wavefronts
    in_valid = 1'b1; in_cfg_idx = 2'd0; step();
    in_valid = 1'b0; repeat (6) step();
    in_valid = 1'b1; in_cfg_idx = 2'd1; step();
    in_valid = 1'b0; repeat (6) step();

    // Six back-to-back alternating fires; this also uses the last credits
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_cfg_idx = 2'(i % 2);
      step();
    end
    exp_rdy = 1'b0;
    step(); step();
    in_valid = 1'b0; repeat (6) step();

    // One credit returned allows exactly one more fire
    credit_ret = 1'b1; step();
    credit_ret = 1'b0; exp_rdy = 1'b1;
    in_valid = 1'b1; in_cfg_idx = 2'd2; step();
    exp_rdy = 1'b0; step();
    in_valid = 1'b0; repeat (6) step();

    // Return all 8 credits, then one too many
    credit_ret = 1'b1; step();
    exp_rdy = 1'b1;
    repeat (7) step();
    check("err_credit_at_max", err_credit, 1'b0);
    step();
    credit_ret = 1'b0;
    check("err_credit_set", err_credit, 1'b1);
    step();
    check("err_credit_sticky", err_credit, 1'b1);

    // Table write colliding with a fire on the same index uses the old config
    cfg_wr_en = 1'b1; cfg_wr_idx = 2'd0; cfg_wr_data = CFG_NEW;
    in_valid = 1'b1; in_cfg_idx = 2'd0; step();
    cfg_wr_en = 1'b0; step();
    in_valid = 1'b0; repeat (6) step();

    // Drain during streaming
    in_valid = 1'b1; in_cfg_idx = 2'd1; step();
    in_cfg_idx = 2'd2; drain_req = 1'b1; step();
    exp_rdy = 1'b0;
    in_cfg_idx = 2'd3; step();
    check("drain_done_early", drain_done, 1'b0);
    in_valid = 1'b0;
    repeat (4) begin
      step();
      check("drain_done_wait", drain_done, 1'b0);
    end
    step();
    check("drain_done_set", drain_done, 1'b1);
    step();
    check("drain_done_hold", drain_done, 1'b1);
    drain_req = 1'b0; step();
    check("drain_done_clear", drain_done, 1'b0);
    exp_rdy = 1'b1;

    // Reset with wavefronts in flight
    in_valid = 1'b1; in_cfg_idx = 2'd3; step(); step();
    in_valid = 1'b0; step(); step(); step();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dp_hold", dp_hold, 1'b1);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_choice", choice, 40'h0);
    check("mid_rst_err_credit", err_credit, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1; exp_rdy = 1'b0; step();
    exp_rdy = 1'b1;
    in_valid = 1'b1; in_cfg_idx = 2'd0;
    repeat (8) step();
    exp_rdy = 1'b0; step();
    in_valid = 1'b0; repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
